// File: rtl/mcp4725_pkg.sv
// Shared types and constants for the MCP4725 command sequencer.
// Opcodes, command bits, FSM states and per-transaction byte counts.
package mcp4725_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } op_e;

  localparam logic [1:0] C_FAST = 2'b00;
  localparam logic [2:0] C_MEM  = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WBYTE,
    S_RBYTE,
    S_STOP,
    S_POLL
  } state_e;

  typedef enum logic [1:0] {
    T_FAST,
    T_MEM,
    T_READ,
    T_POLL
  } txn_e;

  localparam int unsigned FAST_BYTES = 3;
  localparam int unsigned MEM_BYTES  = 4;
  localparam int unsigned READ_BYTES = 5;
  localparam int unsigned POLL_BYTES = 1;

  function automatic logic is_rd(input txn_e t);
    return (t == T_READ) || (t == T_POLL);
  endfunction

endpackage

// File: rtl/mcp4725_frame.sv
// Byte framer: maps transaction type and byte index to the WRITE byte.
// Index 0 is always the address byte; data bytes follow from index 1.
module mcp4725_frame
  import mcp4725_pkg::*;
#(
  parameter logic [5:0] ADDR_HI = 6'b110000
) (
  input  txn_e        txn_i,
  input  logic [2:0]  idx_i,
  input  logic [11:0] data_i,
  input  logic [1:0]  mode_i,
  input  logic        a0_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = 8'h00;
    if (idx_i == 3'd0) begin
      byte_o = {ADDR_HI, a0_i, is_rd(txn_i)};
    end else if (txn_i == T_FAST) begin
      unique case (idx_i)
        3'd1:    byte_o = {C_FAST, mode_i, data_i[11:8]};
        3'd2:    byte_o = data_i[7:0];
        default: byte_o = 8'h00;
      endcase
    end else if (txn_i == T_MEM) begin
      unique case (idx_i)
        3'd1:    byte_o = {C_MEM, 2'b00, mode_i, 1'b0};
        3'd2:    byte_o = data_i[11:4];
        3'd3:    byte_o = {data_i[3:0], 4'h0};
        default: byte_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/mcp4725_seq.sv
// MCP4725 command sequencer: arbitrates DAC/EEPROM requests, frames them
// into byte commands for an I2C master and polls RDY after EEPROM writes.
module mcp4725_seq
  import mcp4725_pkg::*;
#(
  parameter logic [5:0]  ADDR_HI  = 6'b110000,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] data_i,
  input  logic [1:0]  mode_i,
  input  logic        enable,
  input  logic        writeToMem,
  input  logic        readFromMem,
  input  logic        A0,
  output logic [11:0] data_reg,
  output logic [1:0]  mode_reg,
  output logic [11:0] eeprom_data,
  output logic [1:0]  eeprom_mode,
  output logic        busy,
  output logic        nack_err,
  output logic        poll_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [7:0]  cmd_byte,
  output logic        cmd_nack,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_byte,
  input  logic        rsp_ack
);

  localparam logic [15:0] PMAX = 16'(POLL_MAX);

  state_e      st_q, st_d;
  txn_e        txn_q, txn_d;
  logic [2:0]  idx_q, idx_d;
  logic        wait_q, wait_d;
  logic        rd_pend_q, rd_pend_d;
  logic        wr_pend_q, wr_pend_d;
  logic        abort_q, abort_d;
  logic        rdy_q, rdy_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [11:0] tdat_q, tdat_d;
  logic [1:0]  tpd_q, tpd_d;
  logic [1:0]  rpd_q, rpd_d;
  logic [11:0] rdat_q, rdat_d;
  logic [1:0]  repd_q, repd_d;
  logic [3:0]  rehi_q, rehi_d;
  logic [11:0] dreg_q, dreg_d;
  logic [1:0]  mreg_q, mreg_d;
  logic [11:0] edat_q, edat_d;
  logic [1:0]  emod_q, emod_d;
  logic        nerr_q, nerr_d;
  logic        perr_q, perr_d;
  logic [7:0]  fbyte;
  logic        last_w, last_r;
  op_e         op;

  mcp4725_frame #(.ADDR_HI(ADDR_HI)) u_frame (
    .txn_i  (txn_q),
    .idx_i  (idx_q),
    .data_i (tdat_q),
    .mode_i (tpd_q),
    .a0_i   (A0),
    .byte_o (fbyte)
  );

  assign last_w = (txn_q == T_MEM) ? (idx_q == 3'(MEM_BYTES - 1))
                                   : (idx_q == 3'(FAST_BYTES - 1));
  assign last_r = (txn_q == T_POLL) ? (idx_q == 3'(POLL_BYTES - 1))
                                    : (idx_q == 3'(READ_BYTES - 1));

  always_comb begin
    op = OP_START;
    unique case (1'b1)
      (st_q == S_ADDR),
      (st_q == S_WBYTE): op = OP_WRITE;
      (st_q == S_RBYTE): op = OP_READ;
      (st_q == S_STOP):  op = OP_STOP;
      default:           op = OP_START;
    endcase
  end

  assign cmd_valid   = (st_q != S_IDLE) && !wait_q;
  assign cmd_op      = cmd_valid ? op : OP_START;
  assign cmd_byte    = (cmd_valid && op == OP_WRITE) ? fbyte : 8'h00;
  assign cmd_nack    = cmd_valid && (st_q == S_RBYTE) && last_r;
  assign busy        = (st_q != S_IDLE);
  assign data_reg    = dreg_q;
  assign mode_reg    = mreg_q;
  assign eeprom_data = edat_q;
  assign eeprom_mode = emod_q;
  assign nack_err    = nerr_q;
  assign poll_err    = perr_q;

  always_comb begin
    st_d      = st_q;
    txn_d     = txn_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    rd_pend_d = rd_pend_q | readFromMem;
    wr_pend_d = wr_pend_q | writeToMem;
    abort_d   = abort_q;
    rdy_d     = rdy_q;
    pcnt_d    = pcnt_q;
    tdat_d    = tdat_q;
    tpd_d     = tpd_q;
    rpd_d     = rpd_q;
    rdat_d    = rdat_q;
    repd_d    = repd_q;
    rehi_d    = rehi_q;
    dreg_d    = dreg_q;
    mreg_d    = mreg_q;
    edat_d    = edat_q;
    emod_d    = emod_q;
    nerr_d    = 1'b0;
    perr_d    = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        idx_d   = '0;
        wait_d  = 1'b0;
        abort_d = 1'b0;
        if (rd_pend_d) begin
          rd_pend_d = 1'b0;
          txn_d     = T_READ;
          st_d      = S_START;
        end else if (wr_pend_d) begin
          wr_pend_d = 1'b0;
          txn_d     = T_MEM;
          tdat_d    = data_i;
          tpd_d     = mode_i;
          st_d      = S_START;
        end else if (enable &&
                     ({mode_i, data_i} != {mreg_q, dreg_q})) begin
          txn_d  = T_FAST;
          tdat_d = data_i;
          tpd_d  = mode_i;
          st_d   = S_START;
        end
      end
      S_START, S_POLL: begin
        if (cmd_ready) begin
          st_d  = S_ADDR;
          idx_d = '0;
        end
      end
      S_ADDR: begin
        if (!wait_q) begin
          wait_d = cmd_ready;
        end else if (rsp_valid) begin
          wait_d = 1'b0;
          if (!rsp_ack) begin
            abort_d = 1'b1;
            nerr_d  = 1'b1;
            st_d    = S_STOP;
          end else if (is_rd(txn_q)) begin
            st_d  = S_RBYTE;
            idx_d = '0;
          end else begin
            st_d  = S_WBYTE;
            idx_d = 3'd1;
          end
        end
      end
      S_WBYTE: begin
        if (!wait_q) begin
          wait_d = cmd_ready;
        end else if (rsp_valid) begin
          wait_d = 1'b0;
          if (!rsp_ack) begin
            abort_d = 1'b1;
            nerr_d  = 1'b1;
            st_d    = S_STOP;
          end else if (last_w) begin
            dreg_d = tdat_q;
            mreg_d = tpd_q;
            st_d   = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_RBYTE: begin
        if (!wait_q) begin
          wait_d = cmd_ready;
        end else if (rsp_valid) begin
          wait_d = 1'b0;
          if (txn_q == T_POLL) begin
            rdy_d = rsp_byte[7];
            if (rsp_byte[7]) begin
              edat_d = tdat_q;
              emod_d = tpd_q;
            end
            st_d = S_STOP;
          end else begin
            unique case (idx_q)
              3'd0: rpd_d = rsp_byte[2:1];
              3'd1: rdat_d[11:4] = rsp_byte;
              3'd2: rdat_d[3:0] = rsp_byte[7:4];
              3'd3: begin
                repd_d = rsp_byte[6:5];
                rehi_d = rsp_byte[3:0];
              end
              default: begin
                dreg_d = rdat_q;
                mreg_d = rpd_q;
                emod_d = repd_q;
                edat_d = {rehi_q, rsp_byte};
              end
            endcase
            if (last_r) st_d = S_STOP;
            else        idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cmd_ready) begin
          st_d = S_IDLE;
          if (!abort_q && txn_q == T_MEM) begin
            st_d   = S_POLL;
            txn_d  = T_POLL;
            pcnt_d = '0;
            idx_d  = '0;
          end else if (!abort_q && txn_q == T_POLL && !rdy_q) begin
            // Each finished not-ready poll counts; give up at POLL_MAX.
            if ((pcnt_q + 16'd1) >= PMAX) begin
              perr_d = 1'b1;
            end else begin
              pcnt_d = pcnt_q + 16'd1;
              st_d   = S_POLL;
              idx_d  = '0;
            end
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      txn_q     <= T_FAST;
      idx_q     <= '0;
      wait_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      abort_q   <= 1'b0;
      rdy_q     <= 1'b0;
      pcnt_q    <= '0;
      tdat_q    <= '0;
      tpd_q     <= '0;
      rpd_q     <= '0;
      rdat_q    <= '0;
      repd_q    <= '0;
      rehi_q    <= '0;
      dreg_q    <= '0;
      mreg_q    <= '0;
      edat_q    <= '0;
      emod_q    <= '0;
      nerr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      txn_q     <= txn_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      abort_q   <= abort_d;
      rdy_q     <= rdy_d;
      pcnt_q    <= pcnt_d;
      tdat_q    <= tdat_d;
      tpd_q     <= tpd_d;
      rpd_q     <= rpd_d;
      rdat_q    <= rdat_d;
      repd_q    <= repd_d;
      rehi_q    <= rehi_d;
      dreg_q    <= dreg_d;
      mreg_q    <= mreg_d;
      edat_q    <= edat_d;
      emod_q    <= emod_d;
      nerr_q    <= nerr_d;
      perr_q    <= perr_d;
    end
  end

endmodule

// File: tb/tb_mcp4725_seq.sv
// Bench for mcp4725_seq: an I2C-master/device model answers commands and
// every logged command stream is compared against sequences built here.
module tb_mcp4725_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] data_i = '0;
  logic [1:0]  mode_i = '0;
  logic        enable = 1'b0;
  logic        writeToMem = 1'b0;
  logic        readFromMem = 1'b0;
  logic        A0 = 1'b0;
  logic [11:0] data_reg, eeprom_data;
  logic [1:0]  mode_reg, eeprom_mode;
  logic        busy, nack_err, poll_err;
  logic        cmd_valid, cmd_nack;
  logic        cmd_ready = 1'b0;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_byte;
  logic        rsp_valid = 1'b0;
  logic [7:0]  rsp_byte = '0;
  logic        rsp_ack = 1'b0;

  mcp4725_seq #(.POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .mode_i(mode_i),
    .enable(enable), .writeToMem(writeToMem),
    .readFromMem(readFromMem), .A0(A0),
    .data_reg(data_reg), .mode_reg(mode_reg),
    .eeprom_data(eeprom_data), .eeprom_mode(eeprom_mode),
    .busy(busy), .nack_err(nack_err), .poll_err(poll_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_byte(cmd_byte), .cmd_nack(cmd_nack),
    .rsp_valid(rsp_valid), .rsp_byte(rsp_byte), .rsp_ack(rsp_ack)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] E_START = {2'd0, 1'b0, 8'h00};
  localparam logic [10:0] E_STOP  = {2'd3, 1'b0, 8'h00};

  int checks = 0;
  int errors = 0;

  // device / master model state
  logic [10:0] log_m [4096];
  int          log_n = 0;
  logic [7:0]  rd_mem [256];
  int          rd_wr = 0;
  int          rd_rd = 0;
  int          nack_req = 0;
  int          nack_done = 0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic        pack = 1'b0;
  logic [7:0]  pbyte = '0;
  bit          hold_v = 1'b0;
  logic [10:0] hold_e = '0;
  int          proto_err = 0;
  int          stab_err = 0;
  int          nerr_cnt = 0;
  int          perr_cnt = 0;

  function automatic logic [10:0] cur_ent();
    logic [7:0] b;
    logic       n;
    b = (cmd_op == 2'd1) ? cmd_byte : 8'h00;
    n = (cmd_op == 2'd2) ? cmd_nack : 1'b0;
    return {cmd_op, n, b};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      pend      = 1'b0;
      hold_v    = 1'b0;
    end else begin
      if (nack_err) nerr_cnt++;
      if (poll_err) perr_cnt++;
      rsp_valid = 1'b0;
      if (hold_v && !(cmd_valid && cur_ent() == hold_e)) stab_err++;
      if (pend) begin
        if (cmd_valid) proto_err++;
        cmd_ready = 1'($urandom_range(0, 1));
        if (dly == 0) begin
          rsp_valid = 1'b1;
          rsp_ack   = pack;
          rsp_byte  = pbyte;
          pend      = 1'b0;
        end else begin
          dly--;
        end
      end else begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        if (cmd_valid && cmd_ready) begin
          log_m[log_n] = cur_ent();
          log_n++;
          if (cmd_op == 2'd1) begin
            pend  = 1'b1;
            dly   = $urandom_range(0, 2);
            pbyte = 8'h00;
            pack  = 1'b1;
            if (nack_req > nack_done) begin
              pack = 1'b0;
              nack_done++;
            end
          end else if (cmd_op == 2'd2) begin
            pend  = 1'b1;
            dly   = $urandom_range(0, 2);
            pack  = 1'b1;
            pbyte = 8'h00;
            if (rd_rd < rd_wr) begin
              pbyte = rd_mem[rd_rd];
              rd_rd++;
            end
          end
        end
      end
      hold_v = cmd_valid && !cmd_ready;
      hold_e = cur_ent();
    end
  end

  // reference model
  logic [10:0] exp_m [$];
  int log_seen = 0;
  int md_data = 0, md_mode = 0, md_edata = 0, md_emode = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int addr_b(input int a0, input int rw);
    return (7'h60 + a0) * 2 + rw;
  endfunction

  task automatic ex_wr(input int b);
    exp_m.push_back({2'd1, 1'b0, 8'(b)});
  endtask

  task automatic ex_rd(input logic n);
    exp_m.push_back({2'd2, n, 8'h00});
  endtask

  task automatic push_fast(input int a0, input int pd, input int d);
    exp_m.push_back(E_START);
    ex_wr(addr_b(a0, 0));
    ex_wr(pd * 16 + d / 256);
    ex_wr(d % 256);
    exp_m.push_back(E_STOP);
  endtask

  task automatic push_mem(input int a0, input int pd, input int d);
    exp_m.push_back(E_START);
    ex_wr(addr_b(a0, 0));
    ex_wr(8'h60 + pd * 2);
    ex_wr(d / 16);
    ex_wr((d % 16) * 16);
    exp_m.push_back(E_STOP);
  endtask

  task automatic push_poll(input int a0);
    exp_m.push_back(E_START);
    ex_wr(addr_b(a0, 1));
    ex_rd(1'b1);
    exp_m.push_back(E_STOP);
  endtask

  task automatic push_read(input int a0);
    exp_m.push_back(E_START);
    ex_wr(addr_b(a0, 1));
    for (int i = 0; i < 4; i++) ex_rd(1'b0);
    ex_rd(1'b1);
    exp_m.push_back(E_STOP);
  endtask

  task automatic dev_byte(input int b);
    rd_mem[rd_wr] = 8'(b);
    rd_wr++;
  endtask

  task automatic dev_read(input int b0, input int b1, input int b2,
                          input int b3, input int b4);
    dev_byte(b0); dev_byte(b1); dev_byte(b2); dev_byte(b3); dev_byte(b4);
    md_mode  = (b0 / 2) % 4;
    md_data  = b1 * 16 + b2 / 16;
    md_emode = (b3 / 32) % 4;
    md_edata = (b3 % 16) * 256 + b4;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, log_n - log_seen, exp_m.size());
    for (int i = 0; i < exp_m.size() && log_seen + i < log_n; i++)
      chk(tag, log_m[log_seen + i], exp_m[i]);
    log_seen = log_n;
    exp_m.delete();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_data"}, data_reg, md_data);
    chk({tag, "_mode"}, mode_reg, md_mode);
    chk({tag, "_edata"}, eeprom_data, md_edata);
    chk({tag, "_emode"}, eeprom_mode, md_emode);
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int t = 0;
    while (q < 4 && t < 4000) begin
      @(negedge clk);
      t++;
      if (busy) q = 0;
      else q++;
    end
    chk({tag, "_timeout"}, 32'(t < 4000), 1);
  endtask

  task automatic pulse_rd();
    readFromMem = 1'b1;
    @(negedge clk);
    readFromMem = 1'b0;
  endtask

  task automatic pulse_wr();
    writeToMem = 1'b1;
    @(negedge clk);
    writeToMem = 1'b0;
  endtask

  initial begin
    int d, m, t, ne, pe;
    int b [5];

    repeat (3) @(negedge clk);
    chk("rst_outs", {data_reg, mode_reg, eeprom_data, eeprom_mode,
                     nack_err, poll_err, cmd_valid}, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // fast write, then held inputs must stay silent
    enable = 1'b1; data_i = 12'hA5C; mode_i = 2'd0;
    @(negedge clk);
    wait_quiet("fast0");
    repeat (20) @(negedge clk);
    push_fast(0, 0, 'hA5C);
    md_data = 'hA5C; md_mode = 0;
    check_log("fast0");
    check_regs("fast0");

    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(0, 4095);
      m = $urandom_range(0, 3);
      if (d == md_data && m == md_mode) d = d ^ 1;
      data_i = 12'(d); mode_i = 2'(m);
      @(negedge clk);
      wait_quiet("fastr");
      push_fast(0, m, d);
      md_data = d; md_mode = m;
      check_log("fastr");
      check_regs("fastr");
    end
    enable = 1'b0;

    // NACK on the address byte
    ne = nerr_cnt;
    nack_req++;
    data_i = 12'(md_data ^ 12'h0F0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_quiet("nack");
    exp_m.push_back(E_START);
    ex_wr(addr_b(0, 0));
    exp_m.push_back(E_STOP);
    check_log("nack");
    chk("nack_pulse", nerr_cnt - ne, 1);
    check_regs("nack");

    // EEPROM write with two not-ready polls
    A0 = 1'b1; data_i = 12'h123; mode_i = 2'd1;
    dev_byte($urandom_range(0, 127));
    dev_byte($urandom_range(0, 127));
    dev_byte(128 + $urandom_range(0, 127));
    pe = perr_cnt;
    pulse_wr();
    wait_quiet("mem");
    push_mem(1, 1, 'h123);
    repeat (3) push_poll(1);
    md_data = 'h123; md_mode = 1; md_edata = 'h123; md_emode = 1;
    check_log("mem");
    check_regs("mem");
    chk("mem_no_perr", perr_cnt - pe, 0);

    // read-back with fixed device bytes, then random ones
    dev_read('hC0, 'h7F, 'hF0, 'h43, 'h21);
    pulse_rd();
    wait_quiet("read");
    push_read(1);
    check_log("read");
    chk("read_data", data_reg, 12'h7FF);
    chk("read_edata", eeprom_data, 12'h321);
    check_regs("read");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) b[i] = $urandom_range(0, 255);
      dev_read(b[0], b[1], b[2], b[3], b[4]);
      pulse_rd();
      wait_quiet("readr");
      push_read(1);
      check_log("readr");
      check_regs("readr");
    end

    // read and write pulsed together while a fast write is busy
    d = md_data ^ 12'h555;
    data_i = 12'(d); mode_i = 2'(md_mode);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    push_fast(1, md_mode, d);
    @(negedge clk);
    chk("both_busy", busy, 1);
    d = $urandom_range(0, 4095);
    m = $urandom_range(0, 3);
    data_i = 12'(d); mode_i = 2'(m);
    for (int i = 0; i < 5; i++) b[i] = $urandom_range(0, 255);
    dev_read(b[0], b[1], b[2], b[3], b[4]);
    dev_byte(8'h80);
    readFromMem = 1'b1; writeToMem = 1'b1;
    @(negedge clk);
    readFromMem = 1'b0; writeToMem = 1'b0;
    wait_quiet("both");
    push_read(1);
    push_mem(1, m, d);
    push_poll(1);
    md_data = d; md_mode = m; md_edata = d; md_emode = m;
    check_log("both");
    check_regs("both");

    // RDY never set: POLL_MAX polls then poll_err
    pe = perr_cnt;
    d = $urandom_range(0, 4095);
    m = $urandom_range(0, 3);
    data_i = 12'(d); mode_i = 2'(m);
    pulse_wr();
    wait_quiet("tmo");
    push_mem(1, m, d);
    repeat (4) push_poll(1);
    md_data = d; md_mode = m;
    check_log("tmo");
    check_regs("tmo");
    chk("tmo_perr", perr_cnt - pe, 1);

    // reset in the middle of a read byte
    for (int i = 0; i < 5; i++) dev_byte($urandom_range(0, 255));
    pulse_rd();
    t = 0;
    while (!pend && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_reach", 32'(pend), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_outs", {data_reg, mode_reg, eeprom_data, eeprom_mode,
                        nack_err, poll_err, cmd_valid, cmd_op,
                        cmd_byte, cmd_nack}, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_rd = rd_wr;
    log_seen = log_n;
    repeat (20) @(negedge clk);
    chk("rstmid_quiet", log_n - log_seen, 0);

    chk("nack_total", nerr_cnt, 1);
    chk("proto", proto_err, 0);
    chk("stable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcp4725_seq.md
# mcp4725_seq

Command sequencer for the MCP4725 DAC. Sits between the user data/memory-control interface and a byte-level I2C master. Arbitrates between DAC updates, EEPROM writes and read-backs, frames each request into MCP4725 byte sequences, and polls the device's RDY bit after EEPROM programming.

## Interface
- `ADDR_HI`, default `6'b110000`: upper six bits of the 7-bit device address; the address byte is `{ADDR_HI, A0, rw}`.
- `POLL_MAX`, default `255`: maximum RDY polls after an EEPROM write before an error is reported.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `data_i` in 12: requested DAC code.
- `mode_i` in 2: requested power-down bits PD1:PD0.
- `enable` in 1: level signal; while high, any difference between `{mode_i,data_i}` and `{mode_reg,data_reg}` triggers a fast write.
- `writeToMem` in 1: pulse; write `{mode_i,data_i}` to the DAC register and EEPROM.
- `readFromMem` in 1: pulse; read back the device registers.
- `A0` in 1: address pin strap.
- `data_reg` out 12: last confirmed DAC code.
- `mode_reg` out 2: last confirmed PD bits.
- `eeprom_data` out 12: EEPROM code from the last read.
- `eeprom_mode` out 2: EEPROM PD bits from the last read.
- `busy` out 1: high whenever not in IDLE.
- `nack_err` out 1: one-cycle pulse on NACK abort.
- `poll_err` out 1: one-cycle pulse on poll timeout.
- `cmd_valid` out 1, `cmd_ready` in 1: command handshake to the I2C master.
- `cmd_op` out 2: command opcode; 0 START, 1 WRITE, 2 READ, 3 STOP.
- `cmd_byte` out 8: byte for WRITE.
- `cmd_nack` out 1: for READ, send NACK (last byte).
- `rsp_valid` in 1: response strobe, one per WRITE or READ command.
- `rsp_byte` in 8: received byte for READ.
- `rsp_ack` in 1: slave ACK for WRITE.

## Operation
- Arbitration in IDLE, fixed priority: readFromMem > writeToMem > enable-change. Pulses arriving while busy are latched (one pending flag each) and served after the current transaction. The enable-change condition is re-evaluated in IDLE only.
- Fast write (3 bytes): addr(W); `{2'b00, PD, D[11:8]}`; `D[7:0]`.
- Memory write (4 bytes): addr(W); `{3'b011, 2'b00, PD, 1'b0}`; `D[11:4]`; `{D[3:0], 4'h0}`.
- Read (addr(R), then 5 READ commands, the last with `cmd_nack=1`):
  - byte0: status, RDY = bit7, PD = bits[2:1].
  - byte1: `D[11:4]`.
  - byte2: `D[3:0]` in the high nibble.
  - byte3: EEPROM PD = bits[6:5], EEPROM `D[11:8]` = bits[3:0].
  - byte4: EEPROM `D[7:0]`.
- Register updates:
  - Read: `data_reg`, `mode_reg`, `eeprom_data` and `eeprom_mode` update only after the final byte is received.
  - Write: `data_reg` and `mode_reg` update after the final byte's ACK.
- Every transaction ends with STOP.
- States:
  - IDLE → START → ADDR → WBYTE or RBYTE → STOP → IDLE.
  - After a memory write: STOP → POLL.
  - POLL runs a read transaction (addr(R), one READ with NACK, STOP).
  - RDY=1 → IDLE, with `eeprom_data`/`eeprom_mode` set to the written values.
  - RDY=0 → repeat the poll.
- NACK on any WRITE: go to STOP, pulse `nack_err`, leave registers unchanged, drop the transaction. A pending memory write is consumed and not retried.
- Poll counter reaching `POLL_MAX` with RDY still 0: STOP, pulse `poll_err`, go to IDLE.
- Reset values: all outputs 0, state IDLE, pending flags cleared, poll counter 0.
- Reset mid-transaction drops `cmd_valid` the next cycle without issuing STOP. Bus recovery is the I2C master's job.

## Timing
- `cmd_valid` rises at most one cycle after state entry.
- `cmd_valid`, `cmd_op`, `cmd_byte` and `cmd_nack` stay stable until `cmd_valid && cmd_ready`.
- After a WRITE or READ handshake, the sequencer waits for `rsp_valid` before issuing the next command. START and STOP need no response.
- `busy` asserts in the cycle after a request is accepted in IDLE. It deasserts the cycle the state returns to IDLE.
- A request pulse coincident with the IDLE→START transition of another request is latched, not lost.
- Registers update on the `rsp_valid` cycle of the final byte and are visible the next cycle.
- Back-to-back transactions: at least one IDLE cycle between STOP and the next START.

## Structure
- Package `mcp4725_pkg` holds:
  - `cmd_op` encodings.
  - The C2:C0 constants: fast `2'b00`, memory `3'b011`.
  - The state enum.
  - Byte counts: 3, 4, 5, 1.
- Sub-module `mcp4725_frame`: combinational mapping of (transaction type, byte index, data, mode, A0) to `cmd_byte`. The FSM, arbiter, pending flags, poll counter and response capture stay in `mcp4725_seq`.

## Test plan
- `enable=1`, `data_i=12'hA5C`, `mode_i=0`:
  - Required: START, `C0`, `0A`, `5C`, STOP.
  - Then `data_reg=A5C` and no further traffic while inputs are held.
- `writeToMem` with `data_i=12'h123`, `mode_i=2'b01`, `A0=1`:
  - Required: START, `C2`, `62`, `12`, `30`, STOP.
  - Then poll reads return RDY=0 twice, then RDY=1; exactly 3 polls.
  - Then `eeprom_data=123`.
- `readFromMem`, bytes `C0 7F F0 43 21`:
  - Required: `data_reg=7FF`, `mode_reg=0`, `eeprom_data=321`, `eeprom_mode=2`.
  - The 5th READ carries `cmd_nack=1`.
- `rsp_ack=0` on the address byte of a fast write:
  - Required: STOP issued, one-cycle `nack_err`, `data_reg` unchanged.
- `readFromMem` and `writeToMem` pulsed in the same cycle while busy:
  - Required: the read is served first, then the write.
- RDY held at 0 with `POLL_MAX=4`:
  - Required: 4 polls, then `poll_err`.
- `rst` asserted mid-byte:
  - Required: all outputs 0 the next cycle, `busy=0`.
